// File: rtl/mips_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// frame field sizes and the state-to-handshake decode.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } boot_state_t;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CSUM_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned BYTE_CNT_W = $clog2(WORD_BYTES);

    // Only the non-terminal states take bytes from the stream.
    function automatic logic accepts_bytes(input boot_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Assembles MSB-first bytes into 32-bit words; the completed word is presented
// combinationally alongside the 4th byte so the caller can register it.
module boot_word_packer
    import mips_boot_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_word_valid_c,
    output logic [WORD_W-1:0] o_word_c
);

    localparam int unsigned PART_W = WORD_W - BYTE_W;

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [PART_W-1:0]     r_partial;

    // Only the lower three bytes need to be kept; the 4th arrives with the strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_partial <= '0;
        end else if (i_valid) begin
            r_cnt     <= r_cnt + BYTE_CNT_W'(1);
            r_partial <= o_word_c[PART_W-1:0];
        end
    end

    assign o_word_c       = {r_partial, i_byte};
    assign o_word_valid_c = i_valid && (r_cnt == BYTE_CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses length/words/checksum, writes instruction
// memory and keeps the CPU held until the checksum has been verified.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned LEN_W    = HDR_BYTES * BYTE_W;
    localparam int unsigned CSUM_W   = CSUM_BYTES * BYTE_W;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    boot_state_t       r_state;
    boot_state_t       w_state_next;

    logic [BYTE_W-1:0] r_len_hi;
    logic [CNT_W-1:0]  r_word_total;
    logic [CNT_W-1:0]  r_words_loaded;
    logic [CSUM_W-1:0] r_csum;
    logic              r_in_ready;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [WORD_W-1:0] r_imem_wdata;

    logic              w_xfer;
    logic              w_pack_valid;
    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;
    logic [LEN_W-1:0]  w_len;
    logic              w_len_ovf;
    logic              w_last_word;
    logic              w_len_load;
    logic              w_word_wr;
    logic              w_ready_next;
    logic              w_hold_next;
    logic              w_done_next;
    logic              w_error_next;

    assign w_xfer       = in_valid && r_in_ready;
    assign w_pack_valid = w_xfer && ((r_state == DATA) || (r_state == CSUM));
    assign w_len        = {r_len_hi, in_data};
    assign w_len_ovf    = 32'(w_len) > CAPACITY;
    assign w_last_word  = (r_words_loaded + CNT_W'(1)) == r_word_total;

    // Packer is shared: DATA always leaves it at a word boundary before CSUM.
    boot_word_packer u_packer (
        .clock          (clock),
        .reset          (reset),
        .i_valid        (w_pack_valid),
        .i_byte         (in_data),
        .o_word_valid_c (w_word_valid),
        .o_word_c       (w_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= LEN_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_len_load   = 1'b0;
        w_word_wr    = 1'b0;
        w_ready_next = 1'b1;
        w_hold_next  = 1'b1;
        w_done_next  = 1'b0;
        w_error_next = 1'b0;

        case (r_state)
            LEN_HI: begin
                if (w_xfer) begin
                    w_state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_ovf) begin
                        w_state_next = ERR;
                    end else begin
                        w_len_load   = 1'b1;
                        w_state_next = (w_len == '0) ? CSUM : DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_valid) begin
                    w_word_wr = 1'b1;
                    if (w_last_word) begin
                        w_state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                if (w_word_valid) begin
                    w_state_next = (w_word == r_csum) ? DONE : ERR;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase

        // Status outputs are registered from the next state so they track it exactly.
        w_ready_next = accepts_bytes(w_state_next);
        w_hold_next  = (w_state_next != DONE);
        w_done_next  = (w_state_next == DONE);
        w_error_next = (w_state_next == ERR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len_hi       <= '0;
            r_word_total   <= '0;
            r_words_loaded <= '0;
            r_csum         <= '0;
            r_in_ready     <= 1'b1;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
        end else begin
            r_in_ready <= w_ready_next;
            r_cpu_hold <= w_hold_next;
            r_done     <= w_done_next;
            r_error    <= w_error_next;
            r_imem_we  <= w_word_wr;

            if ((r_state == LEN_HI) && w_xfer) begin
                r_len_hi <= in_data;
            end
            if (w_len_load) begin
                r_word_total <= CNT_W'(w_len);
            end
            // Address wraps only through truncation to ADDR_W bits.
            if (w_word_wr) begin
                r_imem_addr    <= ADDR_W'(BASE_ADDR) + r_words_loaded[ADDR_W-1:0];
                r_imem_wdata   <= w_word;
                r_csum         <= r_csum ^ w_word;
                r_words_loaded <= r_words_loaded + CNT_W'(1);
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign words_loaded = r_words_loaded;

endmodule
